// File: rtl/ahb_slave_mem.sv
// ahb_slave_mem: AHB-Lite slave memory with configurable data width, depth,
// wait states, a read-only window and two-cycle ERROR responses.
//
// Ports
//   clk, rst            bus clock, asynchronous active-high reset
//   HSEL, HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADY
//                       AHB-Lite address/control inputs (HBURST, HPROT,
//                       HMASTLOCK are accepted and ignored)
//   HWDATA              write data, sampled only in the DATA cycle
//   HREADYOUT, HRESP    slave ready / response (0 = OKAY, 1 = ERROR)
//   HRDATA              read data, zero outside read DATA cycles
//   dbg_state_o         current FSM state, for checkers
//
// Handshake: an address phase is taken on a rising edge where
// HSEL & HREADY & HTRANS[1] while the slave is not stalling (IDLE, DATA or
// ERR2). A data phase ends on the first edge where HREADYOUT is high; the
// slave holds HREADYOUT low for WAIT_STATES cycles (OKAY) or for the first
// ERROR cycle.
module ahb_slave_mem #(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                DEPTH       = 1024,
    parameter int                WAIT_STATES = 0,
    parameter logic [ADDR_W-1:0] RO_BASE     = '0,
    parameter int                RO_WORDS    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              HSEL,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [2:0]        HBURST,
    input  logic [3:0]        HPROT,
    input  logic [1:0]        HTRANS,
    input  logic              HMASTLOCK,
    input  logic              HREADY,
    input  logic [DATA_W-1:0] HWDATA,
    output logic              HREADYOUT,
    output logic              HRESP,
    output logic [DATA_W-1:0] HRDATA,
    output logic [2:0]        dbg_state_o
);

    localparam int BYTES_W = DATA_W / 8;
    localparam int OFF_W   = $clog2(BYTES_W);
    localparam int IDX_W   = $clog2(DEPTH);
    // Range limits carry one extra bit so the compares cannot wrap.
    localparam logic [ADDR_W:0] SPAN_L = (ADDR_W+1)'(DEPTH * BYTES_W);
    localparam logic [ADDR_W:0] RO_LO  = {1'b0, RO_BASE};
    localparam logic [ADDR_W:0] RO_HI  = RO_LO + (ADDR_W+1)'(RO_WORDS * BYTES_W);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_DATA = 3'd2,
        S_ERR1 = 3'd3,
        S_ERR2 = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                write_q, write_d;
    logic [2:0]          size_q, size_d;
    logic                err_q, err_d;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic                accept;
    logic                addr_err;
    logic [7:0]          size_bytes;
    logic [IDX_W-1:0]    widx;
    logic [BYTES_W-1:0]  lane_en;
    logic                mem_we;
    int                  lane_lo;
    int                  lane_n;
    logic                unused_sink;

    // Address-phase decode, evaluated on the live bus signals.
    always_comb begin
        size_bytes = 8'd1 << HSIZE;
        addr_err   = 1'b0;
        if ({1'b0, HADDR} >= SPAN_L)                      addr_err = 1'b1;
        if (HSIZE > 3'(OFF_W))                            addr_err = 1'b1;
        // HSIZE = 7 gives size_bytes[6:0] = 0, so the mask becomes 7'h7F.
        if (|(HADDR[6:0] & (size_bytes[6:0] - 7'd1)))     addr_err = 1'b1;
        if (HWRITE && {1'b0, HADDR} >= RO_LO && {1'b0, HADDR} < RO_HI) addr_err = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        size_d  = size_q;
        err_d   = err_q;
        accept  = ((state_q == S_IDLE) || (state_q == S_DATA) || (state_q == S_ERR2))
                  && HSEL && HREADY && HTRANS[1];

        unique case (state_q)
            S_WAIT: begin
                if (cnt_q == 4'd0) state_d = S_DATA;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_ERR1:  state_d = S_ERR2;
            default: state_d = S_IDLE;
        endcase

        // A new address phase overrides the fall-back to IDLE.
        if (accept) begin
            addr_d  = HADDR;
            write_d = HWRITE;
            size_d  = HSIZE;
            err_d   = addr_err;
            if (addr_err) begin
                state_d = S_ERR1;
            end else if (WAIT_STATES > 0) begin
                state_d = S_WAIT;
                cnt_d   = 4'(WAIT_STATES - 1);
            end else begin
                state_d = S_DATA;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= 3'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            size_q  <= size_d;
            err_q   <= err_d;
        end
    end

    // Byte lanes touched by the current data phase.
    assign widx    = addr_q[OFF_W +: IDX_W];
    assign lane_lo = int'(addr_q[OFF_W-1:0]);
    assign lane_n  = 1 << size_q;

    always_comb begin
        lane_en = '0;
        for (int i = 0; i < BYTES_W; i++) begin
            if (i >= lane_lo && i < lane_lo + lane_n) lane_en[i] = 1'b1;
        end
    end

    // Only a DATA cycle commits; a reset during WAIT never reaches it.
    assign mem_we = (state_q == S_DATA) && write_q && !rst;

    // Memory contents survive reset, so this array has no reset branch.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < BYTES_W; i++) begin
                if (lane_en[i]) mem[widx][8*i +: 8] <= HWDATA[8*i +: 8];
            end
        end
    end

    assign HREADYOUT   = !((state_q == S_WAIT) || (state_q == S_ERR1));
    assign HRESP       = (state_q == S_ERR1) || (state_q == S_ERR2);
    // Asynchronous read keeps back-to-back read-after-write coherent.
    assign HRDATA      = ((state_q == S_DATA) && !write_q) ? mem[widx] : '0;
    assign dbg_state_o = state_q;

    assign unused_sink = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0], addr_q, err_q};

endmodule
